// File: rtl/exe_div_stallreq_pkg.sv
// Shared constants and types for the EXE-stage iterative divider.
// This package holds the stall-request encodings, the FSM state encodings and the iteration count.
package exe_div_stallreq_pkg;

    localparam int REG_BUS  = 32;
    localparam int DIV_ITER = 32;

    localparam logic PIPELINE_STOP   = 1'b1;
    localparam logic PIPELINE_NOSTOP = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_CALC = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

    // Result signs are captured at issue; the datapath works on magnitudes only.
    typedef struct packed {
        logic neg_quo;
        logic neg_rem;
    } div_sign_t;

endpackage

// File: rtl/exe_div_stallreq_if.sv
// This interface carries the EXE <-> divider signals.
// The EXE side is the master and drives the operands; the divider is the slave and returns the stall request and the results.
interface exe_div_stallreq_if #(
    parameter int DATA_W = 32
);
    logic              div_start;
    logic              div_signed;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              annul;
    logic              stallreq_exe;
    logic              div_ready;
    logic [DATA_W-1:0] div_hi;
    logic [DATA_W-1:0] div_lo;

    modport master (
        output div_start, div_signed, dividend, divisor, annul,
        input  stallreq_exe, div_ready, div_hi, div_lo
    );

    modport slave (
        input  div_start, div_signed, dividend, divisor, annul,
        output stallreq_exe, div_ready, div_hi, div_lo
    );
endinterface

// File: rtl/exe_div_stallreq_div_step.sv
// This module performs one combinational restoring shift-subtract iteration.
// It shifts the next dividend bit into the partial remainder and subtracts the divisor when that fits.
module exe_div_stallreq_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              quo_bit_o
);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // The remainder is always below the divisor, so it fits back into DATA_W bits.
    always_comb begin
        shifted   = {rem_i, bit_i};
        diff      = shifted - {1'b0, divisor_i};
        quo_bit_o = (shifted >= {1'b0, divisor_i});
        rem_o     = quo_bit_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end
endmodule

// File: rtl/exe_div_stallreq.sv
// This is the iterative radix-2 DIV/DIVU unit in EXE. It requests a full pipeline stop while it runs.
// Defining DIV_STALL_COUNT_EN adds the stall_cycles counter output.
module exe_div_stallreq
    import exe_div_stallreq_pkg::*;
#(
    parameter int DATA_W = REG_BUS
) (
    input  logic                    clk,
    input  logic                    rst,
    exe_div_stallreq_if.slave       div_if
`ifdef DIV_STALL_COUNT_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);
    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    div_sign_t         sign_q, sign_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              stall_req;
    logic              ready;
    logic [DATA_W-1:0] step_rem;
    logic              step_bit;
    logic              dvd_neg;
    logic              dsr_neg;

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    exe_div_stallreq_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[DATA_W-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .quo_bit_o (step_bit)
    );

    assign dvd_neg = div_if.div_signed & div_if.dividend[DATA_W-1];
    assign dsr_neg = div_if.div_signed & div_if.divisor[DATA_W-1];

    // NOTE: every variable gets its default before the case statement. A path that misses an assignment would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        sign_d    = sign_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_req = PIPELINE_NOSTOP;
        ready     = 1'b0;

        if (div_if.annul) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (div_if.div_start) begin
                        stall_req      = PIPELINE_STOP;
                        sign_d.neg_quo = dvd_neg ^ dsr_neg;
                        sign_d.neg_rem = dvd_neg;
                        quo_d          = neg_if(dvd_neg, div_if.dividend);
                        dsr_d          = neg_if(dsr_neg, div_if.divisor);
                        rem_d          = '0;
                        cnt_d          = '0;
                        state_d        = (div_if.divisor == '0) ? DIV_ZERO : DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    stall_req = PIPELINE_STOP;
                    quo_d     = {quo_q[DATA_W-2:0], step_bit};
                    rem_d     = step_rem;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = DIV_DONE;
                        lo_d    = neg_if(sign_q.neg_quo, quo_d);
                        hi_d    = neg_if(sign_q.neg_rem, rem_d);
                    end
                end
                DIV_ZERO: begin
                    // quo_q still holds |dividend|; re-applying its sign restores the operand as given.
                    stall_req = PIPELINE_STOP;
                    hi_d      = neg_if(sign_q.neg_rem, quo_q);
                    lo_d      = '1;
                    state_d   = DIV_DONE;
                end
                DIV_DONE: begin
                    ready   = 1'b1;
                    state_d = DIV_IDLE;
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            sign_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // A held div_start must not raise a request while reset is asserted.
    assign div_if.stallreq_exe = rst ? PIPELINE_NOSTOP : stall_req;
    assign div_if.div_ready    = ready;
    assign div_if.div_hi       = hi_q;
    assign div_if.div_lo       = lo_q;

`ifdef DIV_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_req == PIPELINE_STOP) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exe_div_stallreq.sv
// This is the directed bench for exe_div_stallreq. It applies a vector table and then exercises the annul, reset and mid-run start-drop sequences.
// Build it with DIV_STALL_COUNT_EN defined to also check the stall_cycles counter.
module tb_exe_div_stallreq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    exe_div_stallreq_if #(.DATA_W(32)) bus ();

`ifdef DIV_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    exe_div_stallreq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_if       (bus)
`ifdef DIV_STALL_COUNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        int          exp_stall;
        int          exp_ready;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at posedge+1 of the issue cycle. Returns at posedge+1 of the cycle after DONE.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int drop_at, output int stall_n, output int ready_at,
                           output logic [31:0] hi, output logic [31:0] lo);
        stall_n  = 0;
        ready_at = -1;
        hi       = 'x;
        lo       = 'x;
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        for (int c = 0; c < 80; c++) begin
            if (c == drop_at) bus.div_start = 1'b0;
            #1;
            if (bus.stallreq_exe) stall_n++;
            if (bus.div_ready) begin
                ready_at = c;
                hi = bus.div_hi;
                lo = bus.div_lo;
                bus.div_start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        bus.div_start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stall_n, ready_at, exp_total, a_stall;
        logic [31:0] hi, lo;
        bit          ready_seen;

        tbl[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        33, 33};
        tbl[1] = '{1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 33, 33};
        tbl[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h0,        33, 33};
        tbl[3] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000, 33, 33};
        tbl[4] = '{1'b0, 32'h1234,       32'd0,        32'hFFFFFFFF, 32'h1234,     2,  2};
        tbl[5] = '{1'b0, 32'd10,         32'd3,        32'd3,        32'd1,        33, 33};
        tbl[6] = '{1'b0, 32'd9,          32'd2,        32'd4,        32'd1,        33, 33};
        tbl[7] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33, 33};
        tbl[8] = '{1'b1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 2,  2};
        tbl[9] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'd1,        32'd1,        33, 33};

        // Reset with div_start held: no request may leak out.
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd5;
        bus.divisor    = 32'd1;
        bus.annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stallreq", {31'b0, bus.stallreq_exe}, 32'd0);
        check("rst_ready",    {31'b0, bus.div_ready},    32'd0);
        check("rst_hi",       bus.div_hi,                32'd0);
        check("rst_lo",       bus.div_lo,                32'd0);
`ifdef DIV_STALL_COUNT_EN
        check("rst_stall_cycles", stall_cycles, 32'd0);
`endif
        bus.div_start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Consecutive entries issue back to back, in the IDLE cycle that follows DONE.
        exp_total = 0;
        for (int i = 0; i < 10; i++) begin
            run_div(tbl[i].sgn, tbl[i].a, tbl[i].b, -1, stall_n, ready_at, hi, lo);
            exp_total += tbl[i].exp_stall;
            check($sformatf("v%0d_lo", i),    lo,       tbl[i].exp_lo);
            check($sformatf("v%0d_hi", i),    hi,       tbl[i].exp_hi);
            check($sformatf("v%0d_stall", i), stall_n,  tbl[i].exp_stall);
            check($sformatf("v%0d_ready", i), ready_at, tbl[i].exp_ready);
        end
`ifdef DIV_STALL_COUNT_EN
        check("stall_cycles_total", stall_cycles, exp_total);
`endif

        // Annul in the 10th CALC cycle.
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd1000;
        bus.divisor    = 32'd3;
        a_stall    = 0;
        ready_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.stallreq_exe) a_stall++;
            if (bus.div_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
        end
        bus.annul = 1'b1;
        #1;
        check("annul_stall_same_cycle", {31'b0, bus.stallreq_exe}, 32'd0);
        check("annul_ready",            {31'b0, bus.div_ready},    32'd0);
        @(posedge clk); #1;
        bus.annul     = 1'b0;
        bus.div_start = 1'b0;
        #1;
        check("annul_idle_stall", {31'b0, bus.stallreq_exe}, 32'd0);
        check("annul_idle_ready", {31'b0, bus.div_ready},    32'd0);
        check("annul_hi_hold",    bus.div_hi,                tbl[9].exp_hi);
        check("annul_lo_hold",    bus.div_lo,                tbl[9].exp_lo);
        check("annul_pre_stall",  a_stall,                   32'd10);
        check("annul_no_ready",   {31'b0, ready_seen},       32'd0);
        @(posedge clk); #1;
        run_div(1'b0, 32'd1000, 32'd3, -1, stall_n, ready_at, hi, lo);
        check("rerun_lo",    lo,       32'd333);
        check("rerun_hi",    hi,       32'd1);
        check("rerun_stall", stall_n,  32'd33);
        check("rerun_ready", ready_at, 32'd33);

        // Asynchronous reset in the 20th CALC cycle, with div_start still held.
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd50;
        bus.divisor    = 32'd5;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_stallreq", {31'b0, bus.stallreq_exe}, 32'd0);
        check("midrst_ready",    {31'b0, bus.div_ready},    32'd0);
        check("midrst_hi",       bus.div_hi,                32'd0);
        check("midrst_lo",       bus.div_lo,                32'd0);
`ifdef DIV_STALL_COUNT_EN
        check("midrst_stall_cycles", stall_cycles, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        bus.div_start = 1'b0;
        @(posedge clk); #1;

        // div_start drops in CALC; the operation must still complete.
        run_div(1'b0, 32'd77, 32'd4, 5, stall_n, ready_at, hi, lo);
        check("drop_lo",    lo,       32'd19);
        check("drop_hi",    hi,       32'd1);
        check("drop_stall", stall_n,  32'd33);
        check("drop_ready", ready_at, 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
